pma_scan_arbiter: RTL and testbench



---
 rtl/pma_scan_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_pma_scan_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_scan_arbiter.sv
// Round-robin arbiter sharing one PMA range-check bank that scans RulesPerCycle rules per cycle.
// Define PMA_SCAN_EARLY_EXIT_EN to end a scan once all attributes are set or no enabled rule remains.
module pma_scan_arbiter #(
   parameter int unsigned NrReq         = 3,
   parameter int unsigned NrRules       = 16,
   parameter int unsigned RulesPerCycle = 4,
   parameter int unsigned AddrWidth     = 64,
   localparam int unsigned IdW          = (NrReq > 1) ? $clog2(NrReq) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NrReq-1:0]             req_valid_i,
   output logic [NrReq-1:0]             req_ready_o,
   input  logic [NrReq*AddrWidth-1:0]   req_addr_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic [IdW-1:0]               resp_id_o,
   output logic                         resp_hit_o,
   output logic                         resp_exec_o,
   output logic                         resp_cache_o,
   output logic                         resp_nonidem_o,
   input  logic [NrRules-1:0]           rule_en_i,
   input  logic [NrRules*AddrWidth-1:0] rule_base_i,
   input  logic [NrRules*AddrWidth-1:0] rule_len_i,
   input  logic [NrRules*3-1:0]         rule_attr_i,
   input  logic                         cfg_update_i,
   output logic                         busy_o
);

   localparam int unsigned NrGroups = NrRules / RulesPerCycle;
   localparam int unsigned GrpW     = (NrGroups > 1) ? $clog2(NrGroups) : 1;
   localparam int unsigned RuleW    = (NrRules > 1) ? $clog2(NrRules) : 1;

   typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [IdW-1:0]       r_ptr;
   logic [IdW-1:0]       r_id;
   logic [AddrWidth-1:0] r_addr;
   logic [GrpW-1:0]      r_grp;
   logic                 r_hit;
   logic                 r_exec;
   logic                 r_cache;
   logic                 r_nonidem;

   logic                 w_gnt_vld;
   logic [IdW-1:0]       w_gnt_idx;
   logic [IdW-1:0]       w_ptr_nxt;
   logic [AddrWidth-1:0] w_gnt_addr;
   logic                 w_grp_hit;
   logic                 w_grp_exec;
   logic                 w_grp_cache;
   logic                 w_grp_nonidem;
   logic                 w_acc_exec;
   logic                 w_acc_cache;
   logic                 w_acc_nonidem;
   logic                 w_last_grp;
   logic                 w_scan_done;

   // Round-robin search starting at r_ptr, wrapping at NrReq.
   always_comb begin
      logic [IdW:0]   v_sum;
      logic [IdW-1:0] v_cand;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      v_sum     = '0;
      v_cand    = '0;
      for (int unsigned i = 0; i < NrReq; i++) begin
         v_sum = {1'b0, r_ptr} + (IdW+1)'(i);
         if (v_sum >= (IdW+1)'(NrReq)) begin
            v_sum = v_sum - (IdW+1)'(NrReq);
         end
         v_cand = v_sum[IdW-1:0];
         if (!w_gnt_vld && req_valid_i[v_cand]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = v_cand;
         end
      end
   end

   always_comb begin
      if (32'(w_gnt_idx) + 32'd1 >= NrReq) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_gnt_idx + 1'b1;
      end
   end

   assign w_gnt_addr = req_addr_i[32'(w_gnt_idx)*AddrWidth +: AddrWidth];

   // Limit computed one bit wider so base+len cannot wrap.
   always_comb begin
      logic [RuleW-1:0]   v_r;
      logic [AddrWidth-1:0] v_base;
      logic [AddrWidth-1:0] v_len;
      logic [AddrWidth:0]   v_end;
      logic [2:0]           v_attr;
      w_grp_hit     = 1'b0;
      w_grp_exec    = 1'b0;
      w_grp_cache   = 1'b0;
      w_grp_nonidem = 1'b0;
      v_r           = '0;
      v_base        = '0;
      v_len         = '0;
      v_end         = '0;
      v_attr        = '0;
      for (int unsigned j = 0; j < RulesPerCycle; j++) begin
         v_r    = RuleW'(32'(r_grp) * RulesPerCycle + j);
         v_base = rule_base_i[32'(v_r)*AddrWidth +: AddrWidth];
         v_len  = rule_len_i[32'(v_r)*AddrWidth +: AddrWidth];
         v_attr = rule_attr_i[32'(v_r)*3 +: 3];
         v_end  = {1'b0, v_base} + {1'b0, v_len};
         if (rule_en_i[v_r] && (r_addr >= v_base) && ({1'b0, r_addr} < v_end)) begin
            w_grp_hit     = 1'b1;
            w_grp_exec    = w_grp_exec | v_attr[0];
            w_grp_cache   = w_grp_cache | v_attr[1];
            w_grp_nonidem = w_grp_nonidem | v_attr[2];
         end
      end
   end

   assign w_acc_exec    = r_exec | w_grp_exec;
   assign w_acc_cache   = r_cache | w_grp_cache;
   assign w_acc_nonidem = r_nonidem | w_grp_nonidem;
   assign w_last_grp    = (r_grp == GrpW'(NrGroups - 1));

`ifdef PMA_SCAN_EARLY_EXIT_EN
   logic w_rest_en;

   always_comb begin
      w_rest_en = 1'b0;
      for (int unsigned k = 0; k < NrRules; k++) begin
         if ((k >= (32'(r_grp) + 32'd1) * RulesPerCycle) && rule_en_i[RuleW'(k)]) begin
            w_rest_en = 1'b1;
         end
      end
   end

   assign w_scan_done = w_last_grp || !w_rest_en || (w_acc_exec && w_acc_cache && w_acc_nonidem);
`else
   assign w_scan_done = w_last_grp;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_gnt_vld) begin
               w_state_nxt = StScan;
            end
         end
         StScan: begin
            if (!cfg_update_i && w_scan_done) begin
               w_state_nxt = StResp;
            end
         end
         StResp: begin
            if (resp_ready_i) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      req_ready_o    = '0;
      busy_o         = (r_state != StIdle);
      resp_valid_o   = 1'b0;
      resp_id_o      = '0;
      resp_hit_o     = 1'b0;
      resp_exec_o    = 1'b0;
      resp_cache_o   = 1'b0;
      resp_nonidem_o = 1'b0;
      if (r_state == StIdle && w_gnt_vld && !rst_i) begin
         req_ready_o[w_gnt_idx] = 1'b1;
      end
      if (r_state == StResp) begin
         resp_valid_o   = 1'b1;
         resp_id_o      = r_id;
         resp_hit_o     = r_hit;
         resp_exec_o    = r_exec;
         resp_cache_o   = r_cache;
         resp_nonidem_o = r_nonidem;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr     <= '0;
         r_id      <= '0;
         r_addr    <= '0;
         r_grp     <= '0;
         r_hit     <= 1'b0;
         r_exec    <= 1'b0;
         r_cache   <= 1'b0;
         r_nonidem <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_gnt_vld) begin
                  r_ptr     <= w_ptr_nxt;
                  r_id      <= w_gnt_idx;
                  r_addr    <= w_gnt_addr;
                  r_grp     <= '0;
                  r_hit     <= 1'b0;
                  r_exec    <= 1'b0;
                  r_cache   <= 1'b0;
                  r_nonidem <= 1'b0;
               end
            end
            StScan: begin
               // A table change invalidates everything gathered so far.
               if (cfg_update_i) begin
                  r_grp     <= '0;
                  r_hit     <= 1'b0;
                  r_exec    <= 1'b0;
                  r_cache   <= 1'b0;
                  r_nonidem <= 1'b0;
               end else begin
                  r_grp     <= r_grp + 1'b1;
                  r_hit     <= r_hit | w_grp_hit;
                  r_exec    <= w_acc_exec;
                  r_cache   <= w_acc_cache;
                  r_nonidem <= w_acc_nonidem;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pma_scan_arbiter.sv
// Scoreboard bench for pma_scan_arbiter: expected responses queued at grant, checked at output.
module tb_pma_scan_arbiter;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [2:0]    req_valid_i;
   logic [2:0]    req_ready_o;
   logic [191:0]  req_addr_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [1:0]    resp_id_o;
   logic          resp_hit_o;
   logic          resp_exec_o;
   logic          resp_cache_o;
   logic          resp_nonidem_o;
   logic [15:0]   rule_en_i;
   logic [1023:0] rule_base_i;
   logic [1023:0] rule_len_i;
   logic [47:0]   rule_attr_i;
   logic          cfg_update_i;
   logic          busy_o;

   logic [63:0] tb_addr [3];
   logic [63:0] tb_base [16];
   logic [63:0] tb_len  [16];
   logic        tb_en   [16];
   logic [2:0]  tb_attr [16];

   typedef struct packed {
      logic [1:0] id;
      logic       hit;
      logic       exec;
      logic       cache;
      logic       nonidem;
   } resp_t;

   typedef struct {
      resp_t       r;
      int unsigned lat;
      int unsigned gcyc;
   } exp_t;

   exp_t        exp_q [$];
   int unsigned gnt_log [$];
   int unsigned cyc = 0;
   logic        resp_seen = 1'b0;
   exp_t        mon_e;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   pma_scan_arbiter u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_addr_i     (req_addr_i),
      .resp_valid_o   (resp_valid_o),
      .resp_ready_i   (resp_ready_i),
      .resp_id_o      (resp_id_o),
      .resp_hit_o     (resp_hit_o),
      .resp_exec_o    (resp_exec_o),
      .resp_cache_o   (resp_cache_o),
      .resp_nonidem_o (resp_nonidem_o),
      .rule_en_i      (rule_en_i),
      .rule_base_i    (rule_base_i),
      .rule_len_i     (rule_len_i),
      .rule_attr_i    (rule_attr_i),
      .cfg_update_i   (cfg_update_i),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   always_comb begin
      for (int k = 0; k < 3; k++) req_addr_i[k*64 +: 64] = tb_addr[k];
      for (int i = 0; i < 16; i++) begin
         rule_en_i[i]           = tb_en[i];
         rule_base_i[i*64 +: 64] = tb_base[i];
         rule_len_i[i*64 +: 64]  = tb_len[i];
         rule_attr_i[i*3 +: 3]   = tb_attr[i];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: offset form (addr - base < len) avoids computing base+len at all.
   function automatic resp_t model(input int unsigned id, input logic [63:0] addr);
      resp_t m;
      m    = '0;
      m.id = 2'(id);
      for (int i = 0; i < 16; i++) begin
         if (tb_en[i] && addr >= tb_base[i] && (addr - tb_base[i]) < tb_len[i]) begin
            m.hit     = 1'b1;
            m.exec    = m.exec | tb_attr[i][0];
            m.cache   = m.cache | tb_attr[i][1];
            m.nonidem = m.nonidem | tb_attr[i][2];
         end
      end
      return m;
   endfunction

   always @(negedge clk_i) begin
      if (rst_i) begin
         exp_q.delete();
         resp_seen = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (req_ready_o[k]) begin
               mon_e.r    = model(k, tb_addr[k]);
               mon_e.lat  = 5;
               mon_e.gcyc = cyc;
               exp_q.push_back(mon_e);
               gnt_log.push_back(k);
            end
         end
         if (resp_valid_o) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 64'd1, 64'd0);
            end else begin
               check("resp_fields",
                     {58'd0, resp_id_o, resp_hit_o, resp_exec_o, resp_cache_o, resp_nonidem_o},
                     64'(exp_q[0].r));
               if (!resp_seen) begin
`ifdef PMA_SCAN_EARLY_EXIT_EN
                  check("latency_max", 64'(cyc - exp_q[0].gcyc <= exp_q[0].lat), 64'd1);
`else
                  check("latency", 64'(cyc - exp_q[0].gcyc), 64'(exp_q[0].lat));
`endif
                  resp_seen = 1'b1;
               end
               if (resp_ready_i) begin
                  void'(exp_q.pop_front());
                  resp_seen = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input int unsigned k, input logic [63:0] addr);
      int unsigned n;
      n          = 0;
      tb_addr[k] = addr;
      req_valid_i[k] = 1'b1;
      #1;
      while (!req_ready_o[k]) begin
         if (n == 50) begin
            check("grant_timeout", 64'd0, 64'd1);
            break;
         end
         tick();
         n++;
      end
      tick();
      req_valid_i[k] = 1'b0;
   endtask

   task automatic wait_done();
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 || busy_o) begin
         if (n == 100) begin
            check("done_timeout", 64'd0, 64'd1);
            break;
         end
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      req_valid_i  = '0;
      resp_ready_i = 1'b1;
      cfg_update_i = 1'b0;
      for (int k = 0; k < 3; k++) tb_addr[k] = '0;
      for (int i = 0; i < 16; i++) begin
         tb_base[i] = '0;
         tb_len[i]  = '0;
         tb_en[i]   = 1'b0;
         tb_attr[i] = '0;
      end
      tb_base[0]  = 64'h8000_0000;
      tb_len[0]   = 64'h4000_0000;
      tb_attr[0]  = 3'b011;
      tb_en[0]    = 1'b1;
      tb_base[5]  = 64'hFFFF_FFFF_FFFF_F000;
      tb_len[5]   = 64'h1000;
      tb_attr[5]  = 3'b100;
      tb_en[5]    = 1'b1;
      tb_base[9]  = 64'h1000;
      tb_len[9]   = 64'h0;
      tb_attr[9]  = 3'b111;
      tb_en[9]    = 1'b1;
      tb_base[14] = 64'hA000_0000;
      tb_len[14]  = 64'h1000_0000;
      tb_attr[14] = 3'b100;
      tb_en[14]   = 1'b1;

      repeat (3) tick();
      rst_i = 1'b0;
      check("reset_busy", 64'(busy_o), 64'd0);
      check("reset_valid", 64'(resp_valid_o), 64'd0);
      check("reset_ready", 64'(req_ready_o), 64'd0);

      issue(1, 64'h8000_1000);
      wait_done();
      issue(0, 64'hC000_0000);
      wait_done();
      issue(2, 64'hBFFF_FFFF);
      wait_done();
      issue(1, 64'hFFFF_FFFF_FFFF_FFF8);
      wait_done();
      issue(0, 64'h1000);
      wait_done();
      issue(2, 64'hA000_0010);
      wait_done();

      // Backpressure: response must stay put while not consumed.
      resp_ready_i = 1'b0;
      issue(0, 64'h8000_0004);
      n = 0;
      while (!resp_valid_o && n < 50) begin
         tick();
         n++;
      end
      check("bp_valid_seen", 64'(resp_valid_o), 64'd1);
      repeat (4) begin
         tick();
         check("bp_valid_hold", 64'(resp_valid_o), 64'd1);
      end
      resp_ready_i = 1'b1;
      wait_done();

      // Table rewrite in the second scan cycle restarts the scan.
      issue(1, 64'h9000_0000);
      tick();
      tb_en[0]    = 1'b0;
      tb_base[7]  = 64'h9000_0000;
      tb_len[7]   = 64'h10;
      tb_attr[7]  = 3'b100;
      tb_en[7]    = 1'b1;
      cfg_update_i = 1'b1;
      mon_e = exp_q.pop_back();
      mon_e.r   = model(1, 64'h9000_0000);
      mon_e.lat = 7;
      exp_q.push_back(mon_e);
      tick();
      cfg_update_i = 1'b0;
      wait_done();

      // Reset during scan drops the transaction and rewinds the pointer.
      issue(0, 64'hA000_0000);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_mid_busy", 64'(busy_o), 64'd0);
      check("rst_mid_valid", 64'(resp_valid_o), 64'd0);
      repeat (6) tick();
      check("rst_no_resp", 64'(resp_valid_o), 64'd0);

      gnt_log.delete();
      tb_addr[0]  = 64'hA000_0100;
      tb_addr[1]  = 64'h9000_0008;
      tb_addr[2]  = 64'h0000_0040;
      req_valid_i = 3'b111;
      n = 0;
      while (gnt_log.size() < 6 && n < 200) begin
         tick();
         n++;
      end
      req_valid_i = 3'b000;
      check("rr_count", 64'(gnt_log.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < gnt_log.size()) check("rr_order", 64'(gnt_log[i]), 64'(i % 3));
      end
      wait_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
